// File: rtl/sha256_padder.sv
// SHA-256 message padder: turns a raw word stream of a given bit length into whole
// 16-word padded blocks on the FIFO write side. Build option: SHA256_PAD_BYTESWAP_EN.
module sha256_padder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] bit_len_i,
    output logic        ready_o,
    input  logic        in_vld_i,
    input  logic [31:0] in_dat_i,
    output logic        in_rdy_o,
    input  logic        fifo_full_i,
    output logic        fifo_wr_en_o,
    output logic [31:0] fifo_wr_dat_o,
    output logic        done_o,
    output logic [15:0] blk_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PAD1,
        S_ZERO,
        S_LENHI,
        S_LENLO
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [27:0] nwords_q, nwords_d;
    logic [3:0]  wpos_q, wpos_d;
    logic [15:0] blk_cnt_q, blk_cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_dat_q, wr_dat_d;
    logic        done_q, done_d;

    logic [31:0] in_word;
    logic [31:0] masked_word;
    logic [4:0]  rem_bits;
    logic [3:0]  wpos_nxt;
    logic        do_wr;
    logic [31:0] wr_val;

`ifdef SHA256_PAD_BYTESWAP_EN
    assign in_word = {in_dat_i[7:0], in_dat_i[15:8], in_dat_i[23:16], in_dat_i[31:24]};
`else
    assign in_word = in_dat_i;
`endif

    assign rem_bits    = len_q[4:0];
    assign wpos_nxt    = wpos_q + 4'd1;
    // Keep the r valid message bits of the last word and append the '1' right after them.
    assign masked_word = (in_word & (32'hFFFF_FFFF << (6'd32 - {1'b0, rem_bits})))
                       | (32'h1 << (5'd31 - rem_bits));

    // ready drops for the done cycle so it rises the cycle after done_o.
    assign ready_o       = (state_q == S_IDLE) && !done_q;
    assign in_rdy_o      = (state_q == S_DATA) && !fifo_full_i;
    assign fifo_wr_en_o  = wr_en_q;
    assign fifo_wr_dat_o = wr_dat_q;
    assign done_o        = done_q;
    assign blk_cnt_o     = blk_cnt_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        nwords_d  = nwords_q;
        wpos_d    = wpos_q;
        blk_cnt_d = blk_cnt_q;
        wr_en_d   = 1'b0;
        wr_dat_d  = wr_dat_q;
        done_d    = 1'b0;
        do_wr     = 1'b0;
        wr_val    = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (start_i && ready_o) begin
                    len_d     = bit_len_i;
                    nwords_d  = {1'b0, bit_len_i[31:5]} + {27'd0, |bit_len_i[4:0]};
                    wpos_d    = 4'd0;
                    blk_cnt_d = 16'd0;
                    state_d   = (bit_len_i != 32'd0) ? S_DATA : S_PAD1;
                end
            end
            S_DATA: begin
                if (in_vld_i && !fifo_full_i) begin
                    do_wr    = 1'b1;
                    nwords_d = nwords_q - 28'd1;
                    wr_val   = in_word;
                    if (nwords_q == 28'd1) begin
                        if (rem_bits != 5'd0) begin
                            wr_val  = masked_word;
                            state_d = (wpos_nxt == 4'd14) ? S_LENHI : S_ZERO;
                        end else begin
                            state_d = S_PAD1;
                        end
                    end
                end
            end
            S_PAD1: begin
                if (!fifo_full_i) begin
                    do_wr   = 1'b1;
                    wr_val  = 32'h8000_0000;
                    state_d = (wpos_nxt == 4'd14) ? S_LENHI : S_ZERO;
                end
            end
            S_ZERO: begin
                if (!fifo_full_i) begin
                    do_wr = 1'b1;
                    if (wpos_nxt == 4'd14) begin
                        state_d = S_LENHI;
                    end
                end
            end
            S_LENHI: begin
                if (!fifo_full_i) begin
                    do_wr   = 1'b1;
                    state_d = S_LENLO;
                end
            end
            S_LENLO: begin
                if (!fifo_full_i) begin
                    do_wr   = 1'b1;
                    wr_val  = len_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_wr) begin
            wr_en_d  = 1'b1;
            wr_dat_d = wr_val;
            wpos_d   = wpos_nxt;
            if (wpos_q == 4'd15) begin
                blk_cnt_d = blk_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            len_q     <= 32'd0;
            nwords_q  <= 28'd0;
            wpos_q    <= 4'd0;
            blk_cnt_q <= 16'd0;
            wr_en_q   <= 1'b0;
            wr_dat_q  <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            nwords_q  <= nwords_d;
            wpos_q    <= wpos_d;
            blk_cnt_q <= blk_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_dat_q  <= wr_dat_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: expected FIFO words are queued as stimulus is driven and
// popped as the padder writes them.
module tb_sha256_padder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] bit_len_i = 32'd0;
    logic        ready_o;
    logic        in_vld_i = 1'b0;
    logic [31:0] in_dat_i = 32'd0;
    logic        in_rdy_o;
    logic        fifo_full_i = 1'b0;
    logic        fifo_wr_en_o;
    logic [31:0] fifo_wr_dat_o;
    logic        done_o;
    logic [15:0] blk_cnt_o;

    sha256_padder dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .bit_len_i    (bit_len_i),
        .ready_o      (ready_o),
        .in_vld_i     (in_vld_i),
        .in_dat_i     (in_dat_i),
        .in_rdy_o     (in_rdy_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_wr_dat_o(fifo_wr_dat_o),
        .done_o       (done_o),
        .blk_cnt_o    (blk_cnt_o)
    );

    always #4 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] dat;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic full_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] swp(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] src_word(input logic [31:0] len, input int i);
        logic [31:0] w;
`ifdef SHA256_PAD_BYTESWAP_EN
        if (len == 32'd24) w = 32'h0063_6261;
`else
        if (len == 32'd24) w = 32'h6162_6300;
`endif
        else w = 32'hA500_0000 + 32'h0101_0101 * i[31:0] + len;
        return w;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] raw, input bit is_last, input int r);
        logic [31:0] w;
`ifdef SHA256_PAD_BYTESWAP_EN
        w = swp(raw);
`else
        w = raw;
`endif
        if (is_last && r != 0) w = (w & ~(32'hFFFF_FFFF >> r)) | (32'h8000_0000 >> r);
        return w;
    endfunction

    task automatic push_tail(input logic [31:0] len, input int nw, input int r, input int total);
        int nz;
        nz = total - nw - ((r == 0) ? 1 : 0) - 2;
        if (r == 0) exp_q.push_back('{32'h8000_0000, 1'b0});
        for (int k = 0; k < nz; k++) exp_q.push_back('{32'h0, 1'b0});
        exp_q.push_back('{32'h0, 1'b0});
        exp_q.push_back('{len, 1'b1});
    endtask

    always @(posedge clk_i) full_seen <= fifo_full_i;

    always @(negedge clk_i) begin
        if (!rst_i && fifo_wr_en_o) begin
            chk("no_write_when_full", {31'd0, full_seen}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", fifo_wr_dat_o, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_dat", fifo_wr_dat_o, e.dat);
                chk("done_on_last", {31'd0, done_o}, {31'd0, e.last});
            end
        end else if (!rst_i && done_o) begin
            chk("stray_done", 32'd1, 32'd0);
        end
    end

    task automatic run_job(input logic [31:0] len, input bit rnd_full, input int abort_after,
                           input bit poke_busy);
        int nw, r, total, acc, cyc;
        bit saw_rdy, got_done;
        nw = (int'(len) + 31) / 32;
        r = int'(len) % 32;
        total = 16 * ((int'(len) + 65 + 511) / 512);
        acc = 0;
        cyc = 0;
        saw_rdy = 0;
        got_done = 0;
        if (nw == 0) push_tail(len, nw, r, total);

        @(negedge clk_i);
        chk("ready_before_start", {31'd0, ready_o}, 32'd1);
        start_i = 1'b1;
        bit_len_i = len;
        in_vld_i = (nw == 0);
        @(negedge clk_i);
        start_i = 1'b0;
        chk("ready_low_after_start", {31'd0, ready_o}, 32'd0);

        while (cyc < 600) begin
            if (done_o) begin
                got_done = 1;
                chk("ready_low_on_done", {31'd0, ready_o}, 32'd0);
                chk("blk_cnt", {16'd0, blk_cnt_o}, total / 16);
                break;
            end
            if (abort_after >= 0 && acc == abort_after) break;
            fifo_full_i = rnd_full ? 1'($urandom_range(0, 1)) : 1'b0;
            start_i = poke_busy && (cyc == 3);
            bit_len_i = start_i ? 32'd999 : len;
            if (nw > 0) begin
                in_vld_i = (acc < nw);
                in_dat_i = src_word(len, acc);
            end
            #1;
            if (in_rdy_o) saw_rdy = 1;
            if (nw > 0 && in_vld_i && in_rdy_o) begin
                exp_q.push_back('{model_word(in_dat_i, acc == nw - 1, r), 1'b0});
                acc++;
                if (acc == nw) push_tail(len, nw, r, total);
            end
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        bit_len_i = len;

        if (abort_after >= 0) begin
            chk("abort_point_reached", acc, abort_after);
            return;
        end
        chk("job_done_seen", {31'd0, got_done}, 32'd1);
        if (nw == 0) chk("in_rdy_never_high", {31'd0, saw_rdy}, 32'd0);
        in_vld_i = 1'b0;
        fifo_full_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_done", {31'd0, ready_o}, 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
        chk({tag, "_in_rdy"}, {31'd0, in_rdy_o}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, fifo_wr_en_o}, 32'd0);
        chk({tag, "_wr_dat"}, fifo_wr_dat_o, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_blk_cnt"}, {16'd0, blk_cnt_o}, 32'd0);
    endtask

    initial begin
        #18;
        check_reset_vals("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        run_job(32'd24, 1'b0, -1, 1'b0);
        run_job(32'd0, 1'b0, -1, 1'b0);
        run_job(32'd448, 1'b0, -1, 1'b1);
        run_job(32'd512, 1'b1, -1, 1'b0);
        run_job(32'd437, 1'b1, -1, 1'b0);
        run_job(32'd440, 1'b0, -1, 1'b0);

        run_job(32'd768, 1'b0, 5, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_vals("mid_job_reset");
        exp_q.delete();
        in_vld_i = 1'b0;
        fifo_full_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        run_job(32'd24, 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
